// File: rtl/cbl_mir_pkg.sv
// cbl_mir_pkg: shared constants for the microinstruction register and branch logic.
//   Microword field positions, COND and Tipo encodings, sequencer states,
//   PSR flag indices and the ALU opcode group that updates the condition codes.
package cbl_mir_pkg;

   localparam int DATAWIDTH_CSADDRESS = 11;
   localparam int DATAWIDTH_MICROWORD = 41;
   localparam int DATAWIDTH_CBL       = 2;
   localparam int DATAWIDTH_FLAGS     = 4;

   // Microword field bit positions
   localparam int MIR_A_HI     = 40;
   localparam int MIR_A_LO     = 35;
   localparam int MIR_AMUX     = 34;
   localparam int MIR_B_HI     = 33;
   localparam int MIR_B_LO     = 28;
   localparam int MIR_BMUX     = 27;
   localparam int MIR_C_HI     = 26;
   localparam int MIR_C_LO     = 21;
   localparam int MIR_CMUX     = 20;
   localparam int MIR_RD       = 19;
   localparam int MIR_WR       = 18;
   localparam int MIR_ALU_HI   = 17;
   localparam int MIR_ALU_LO   = 14;
   localparam int MIR_COND_HI  = 13;
   localparam int MIR_COND_LO  = 11;
   localparam int MIR_JUMP_HI  = 10;
   localparam int MIR_JUMP_LO  = 0;

   // PSR flag positions inside {n,z,v,c}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   // ALU[3:2] value shared by ANDCC/ORCC/NORCC/ADDCC
   localparam logic [1:0] ALU_CC_GROUP = 2'b00;

   typedef enum logic [2:0] {
      COND_NEXT   = 3'b000,
      COND_N      = 3'b001,
      COND_Z      = 3'b010,
      COND_V      = 3'b011,
      COND_C      = 3'b100,
      COND_IR13   = 3'b101,
      COND_JUMP   = 3'b110,
      COND_DECODE = 3'b111
   } cond_t;

   typedef enum logic [1:0] {
      TIPO_NEXT   = 2'b00,
      TIPO_JUMP   = 2'b01,
      TIPO_DECODE = 2'b10
   } tipo_t;

   typedef enum logic [1:0] {
      ST_LOAD    = 2'b00,
      ST_EXEC    = 2'b01,
      ST_MEMWAIT = 2'b10
   } state_t;

endpackage

// File: rtl/cbl_branch_logic.sv
// cbl_branch_logic: combinational microbranch select.
//   cond     in  3  COND field of the registered microinstruction
//   psr      in  4  registered {n,z,v,c}
//   ir13     in  1  instruction register bit 13
//   complete in  1  microinstruction completes this cycle
//   tipo     out 2  next-address select (00 next, 01 jump, 10 decode)
// While the microinstruction is not completing, Tipo selects "jump" so the
// CS address register reloads its own address and holds.
module cbl_branch_logic
   import cbl_mir_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [3:0] psr,
   input  logic       ir13,
   input  logic       complete,
   output logic [1:0] tipo
);

   // Map COND and the selected flag to the next-address select
   always_comb begin
      tipo = TIPO_JUMP;
      if (complete) begin
         case (cond_t'(cond))
            COND_NEXT:   tipo = TIPO_NEXT;
            COND_N:      tipo = psr[FLAG_N] ? TIPO_JUMP : TIPO_NEXT;
            COND_Z:      tipo = psr[FLAG_Z] ? TIPO_JUMP : TIPO_NEXT;
            COND_V:      tipo = psr[FLAG_V] ? TIPO_JUMP : TIPO_NEXT;
            COND_C:      tipo = psr[FLAG_C] ? TIPO_JUMP : TIPO_NEXT;
            COND_IR13:   tipo = ir13 ? TIPO_JUMP : TIPO_NEXT;
            COND_JUMP:   tipo = TIPO_JUMP;
            COND_DECODE: tipo = TIPO_DECODE;
            default:     tipo = TIPO_JUMP;
         endcase
      end else begin
         tipo = TIPO_JUMP;
      end
   end

endmodule

// File: rtl/cbl_mir.sv
// cbl_mir: microinstruction register, LOAD/EXEC/MEMWAIT sequencer and PSR.
//   CBL_MIR_CLOCK_50            in  1   clock, rising edge
//   CBL_MIR_ResetInLow_In       in  1   async active-low reset
//   CBL_MIR_CSAddress_InBus     in  11  current CS address
//   CBL_MIR_Microword_InBus     in  41  microcode store output
//   CBL_MIR_IR13_In             in  1   IR bit 13
//   CBL_MIR_ALUFlags_InBus      in  4   live ALU {n,z,v,c}
//   CBL_MIR_MemReady_In         in  1   main memory ready
//   CBL_MIR_Tipo_OutBus         out 2   next-address select
//   CBL_MIR_JumpAddress_OutBus  out 11  jump target
//   CBL_MIR_MIR_OutBus          out 41  registered microinstruction
//   CBL_MIR_ExecStrobe_Out      out 1   microinstruction completes this cycle
//   CBL_MIR_MemRead_Out         out 1   memory read request
//   CBL_MIR_MemWrite_Out        out 1   memory write request
//   CBL_MIR_PSR_OutBus          out 4   registered {n,z,v,c}
// Tipo and JumpAddress are combinational because the CS address register
// consumes them on the very next edge; during LOAD and memory wait they
// feed back the current address so the control store holds.
module cbl_mir
   import cbl_mir_pkg::*;
(
   input  logic        CBL_MIR_CLOCK_50,
   input  logic        CBL_MIR_ResetInLow_In,
   input  logic [10:0] CBL_MIR_CSAddress_InBus,
   input  logic [40:0] CBL_MIR_Microword_InBus,
   input  logic        CBL_MIR_IR13_In,
   input  logic [3:0]  CBL_MIR_ALUFlags_InBus,
   input  logic        CBL_MIR_MemReady_In,
   output logic [1:0]  CBL_MIR_Tipo_OutBus,
   output logic [10:0] CBL_MIR_JumpAddress_OutBus,
   output logic [40:0] CBL_MIR_MIR_OutBus,
   output logic        CBL_MIR_ExecStrobe_Out,
   output logic        CBL_MIR_MemRead_Out,
   output logic        CBL_MIR_MemWrite_Out,
   output logic [3:0]  CBL_MIR_PSR_OutBus
);

   state_t      state_r;
   state_t      state_next;
   logic [40:0] mir_r;
   logic [3:0]  psr_r;
   logic        rd;
   logic        wr;
   logic        active;
   logic        complete;

   // Sequencer state register
   always_ff @(posedge CBL_MIR_CLOCK_50 or negedge CBL_MIR_ResetInLow_In) begin
      if (!CBL_MIR_ResetInLow_In) begin
         state_r <= ST_LOAD;
      end else begin
         state_r <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = state_r;
      case (state_r)
         ST_LOAD:    state_next = ST_EXEC;
         ST_EXEC:    state_next = complete ? ST_LOAD : ST_MEMWAIT;
         ST_MEMWAIT: state_next = complete ? ST_LOAD : ST_MEMWAIT;
         default:    state_next = ST_LOAD;
      endcase
   end

   // Output decode: completion and memory request qualifiers
   always_comb begin
      rd       = mir_r[MIR_RD];
      wr       = mir_r[MIR_WR];
      active   = 1'b0;
      complete = 1'b0;
      case (state_r)
         ST_LOAD: begin
            active   = 1'b0;
            complete = 1'b0;
         end
         ST_EXEC, ST_MEMWAIT: begin
            active   = 1'b1;
            // a memory microinstruction only completes once memory is ready
            complete = !(rd || wr) || CBL_MIR_MemReady_In;
         end
         default: begin
            active   = 1'b0;
            complete = 1'b0;
         end
      endcase
      CBL_MIR_ExecStrobe_Out = complete;
      CBL_MIR_MemRead_Out    = active & rd;
      // RD and WR together are treated as a read
      CBL_MIR_MemWrite_Out   = active & wr & ~rd;
      if (complete) begin
         CBL_MIR_JumpAddress_OutBus = mir_r[MIR_JUMP_HI:MIR_JUMP_LO];
      end else begin
         CBL_MIR_JumpAddress_OutBus = CBL_MIR_CSAddress_InBus;
      end
   end

   // Microinstruction register: captured at the end of LOAD, stable otherwise
   always_ff @(posedge CBL_MIR_CLOCK_50 or negedge CBL_MIR_ResetInLow_In) begin
      if (!CBL_MIR_ResetInLow_In) begin
         mir_r <= 41'd0;
      end else if (state_r == ST_LOAD) begin
         mir_r <= CBL_MIR_Microword_InBus;
      end else begin
         mir_r <= mir_r;
      end
   end

   // PSR: condition-code ALU ops latch the live flags on the completing edge,
   // so a branch in the same microinstruction still sees the old flags
   always_ff @(posedge CBL_MIR_CLOCK_50 or negedge CBL_MIR_ResetInLow_In) begin
      if (!CBL_MIR_ResetInLow_In) begin
         psr_r <= 4'd0;
      end else if (complete && (mir_r[MIR_ALU_HI:MIR_ALU_HI-1] == ALU_CC_GROUP)) begin
         psr_r <= CBL_MIR_ALUFlags_InBus;
      end else begin
         psr_r <= psr_r;
      end
   end

   cbl_branch_logic u_branch (
      .cond     (mir_r[MIR_COND_HI:MIR_COND_LO]),
      .psr      (psr_r),
      .ir13     (CBL_MIR_IR13_In),
      .complete (complete),
      .tipo     (CBL_MIR_Tipo_OutBus)
   );

   assign CBL_MIR_MIR_OutBus = mir_r;
   assign CBL_MIR_PSR_OutBus = psr_r;

endmodule

// File: tb/tb_cbl_mir.sv
module tb_cbl_mir;

   logic        clk;
   logic        rst_n;
   logic [10:0] cs_addr;
   logic [40:0] uword;
   logic        ir13;
   logic [3:0]  alu_flags;
   logic        mem_ready;
   logic [1:0]  tipo;
   logic [10:0] jaddr;
   logic [40:0] mir;
   logic        strobe;
   logic        mrd;
   logic        mwr;
   logic [3:0]  psr;

   int checks = 0;
   int errors = 0;
   logic [3:0] m_psr;

   cbl_mir dut (
      .CBL_MIR_CLOCK_50           (clk),
      .CBL_MIR_ResetInLow_In      (rst_n),
      .CBL_MIR_CSAddress_InBus    (cs_addr),
      .CBL_MIR_Microword_InBus    (uword),
      .CBL_MIR_IR13_In            (ir13),
      .CBL_MIR_ALUFlags_InBus     (alu_flags),
      .CBL_MIR_MemReady_In        (mem_ready),
      .CBL_MIR_Tipo_OutBus        (tipo),
      .CBL_MIR_JumpAddress_OutBus (jaddr),
      .CBL_MIR_MIR_OutBus         (mir),
      .CBL_MIR_ExecStrobe_Out     (strobe),
      .CBL_MIR_MemRead_Out        (mrd),
      .CBL_MIR_MemWrite_Out       (mwr),
      .CBL_MIR_PSR_OutBus         (psr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: branch decision from COND, flags {n,z,v,c} and IR13
   function automatic logic [1:0] exp_tipo(input logic [2:0] cond, input logic [3:0] p,
                                           input logic i13);
      logic [1:0] t;
      case (cond)
         3'd0: t = 2'b00;
         3'd1: t = p[3] ? 2'b01 : 2'b00;
         3'd2: t = p[2] ? 2'b01 : 2'b00;
         3'd3: t = p[1] ? 2'b01 : 2'b00;
         3'd4: t = p[0] ? 2'b01 : 2'b00;
         3'd5: t = i13 ? 2'b01 : 2'b00;
         3'd6: t = 2'b01;
         default: t = 2'b10;
      endcase
      return t;
   endfunction

   // Build a microword; A/B/C/mux fields are random filler
   function automatic logic [40:0] mk(input logic rd, input logic wr, input logic [3:0] alu,
                                      input logic [2:0] cond, input logic [10:0] ja);
      logic [40:0] w;
      w[40:20] = 21'($urandom);
      w[19]    = rd;
      w[18]    = wr;
      w[17:14] = alu;
      w[13:11] = cond;
      w[10:0]  = ja;
      return w;
   endfunction

   // One microinstruction, starting just after an edge with the DUT in LOAD
   task automatic run_uinstr(input logic [40:0] w, input logic i13, input logic [3:0] fl,
                             input int nready, input string tag);
      logic [10:0] cs;
      logic        rd;
      logic        wmem;
      logic [1:0]  et;
      rd   = w[19];
      wmem = w[18] & ~w[19];
      cs = 11'($urandom);
      cs_addr = cs; uword = w; ir13 = i13; alu_flags = fl;
      mem_ready = (nready == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (tipo !== 2'b01 || jaddr !== cs || strobe !== 1'b0 || mrd !== 1'b0 || mwr !== 1'b0) begin
         errors++;
         $display("FAIL %s_load: tipo=%b jaddr=%h strobe=%b rd=%b wr=%b, want tipo=01 jaddr=%h strobe=0 rd=0 wr=0",
                  tag, tipo, jaddr, strobe, mrd, mwr, cs);
      end
      checks++;
      @(posedge clk); #1;
      uword = {9'($urandom), $urandom};
      for (int i = 0; i < nready; i++) begin
         mem_ready = 1'b0;
         cs = 11'($urandom);
         cs_addr = cs;
         @(negedge clk);
         if (tipo !== 2'b01 || jaddr !== cs || strobe !== 1'b0 || mrd !== rd || mwr !== wmem || mir !== w) begin
            errors++;
            $display("FAIL %s_wait%0d: tipo=%b jaddr=%h strobe=%b rd=%b wr=%b mir=%h, want tipo=01 jaddr=%h strobe=0 rd=%b wr=%b mir=%h",
                     tag, i, tipo, jaddr, strobe, mrd, mwr, mir, cs, rd, wmem, w);
         end
         checks++;
         @(posedge clk); #1;
      end
      mem_ready = (w[19] | w[18]) ? 1'b1 : 1'($urandom);
      et = exp_tipo(w[13:11], m_psr, i13);
      @(negedge clk);
      if (tipo !== et || jaddr !== w[10:0] || strobe !== 1'b1 || mrd !== rd || mwr !== wmem || mir !== w) begin
         errors++;
         $display("FAIL %s_exec: tipo=%b jaddr=%h strobe=%b rd=%b wr=%b mir=%h, want tipo=%b jaddr=%h strobe=1 rd=%b wr=%b mir=%h",
                  tag, tipo, jaddr, strobe, mrd, mwr, mir, et, w[10:0], rd, wmem, w);
      end
      checks++;
      @(posedge clk);
      if (w[17:16] == 2'b00) m_psr = fl;
      #1;
      if (psr !== m_psr) begin
         errors++;
         $display("FAIL %s_psr: psr=%b want %b", tag, psr, m_psr);
      end
      checks++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cs_addr = 11'h123; uword = 41'd0; ir13 = 1'b0;
      alu_flags = 4'd0; mem_ready = 1'b0; m_psr = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      if (tipo !== 2'b01 || jaddr !== 11'h123 || mir !== 41'd0 || psr !== 4'd0 ||
          strobe !== 1'b0 || mrd !== 1'b0 || mwr !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: tipo=%b jaddr=%h mir=%h psr=%b strobe=%b rd=%b wr=%b", tipo, jaddr, mir, psr, strobe, mrd, mwr);
      end
      checks++;
      rst_n = 1'b1;
      run_uinstr(41'd0, 1'b0, 4'd0, 0, "rst_zero");
      // set PSR non-zero, then reset in the middle of EXEC
      run_uinstr(mk(1'b0, 1'b0, 4'b0011, 3'd0, 11'h111), 1'b0, 4'b1010, 0, "rst_setcc");
      uword = mk(1'b0, 1'b0, 4'b0000, 3'd6, 11'h7FF); cs_addr = 11'h123; alu_flags = 4'b1111;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      if (mir !== 41'd0 || psr !== 4'd0 || strobe !== 1'b0 || tipo !== 2'b01 || jaddr !== 11'h123) begin
         errors++;
         $display("FAIL reset_mid_exec: mir=%h psr=%b strobe=%b tipo=%b jaddr=%h, want 0 0 0 01 123", mir, psr, strobe, tipo, jaddr);
      end
      checks++;
      m_psr = 4'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_jump_always();
      run_uinstr(mk(1'b0, 1'b0, 4'b0100, 3'd6, 11'h5A0), 1'b0, 4'd0, 0, "jump_always");
   endtask

   task automatic test_psr_cc();
      run_uinstr(mk(1'b0, 1'b0, 4'b0011, 3'd0, 11'h010), 1'b0, 4'b1000, 0, "addcc");
      run_uinstr(mk(1'b0, 1'b0, 4'b0100, 3'd1, 11'h020), 1'b0, 4'b0111, 0, "br_n_taken");
      run_uinstr(mk(1'b0, 1'b0, 4'b0000, 3'd0, 11'h030), 1'b0, 4'b0000, 0, "andcc_clear");
      run_uinstr(mk(1'b0, 1'b0, 4'b0100, 3'd0, 11'h040), 1'b0, 4'b1000, 0, "add_nocc");
      run_uinstr(mk(1'b0, 1'b0, 4'b1000, 3'd1, 11'h050), 1'b0, 4'b1111, 0, "br_n_not");
      // same-instruction branch sees the old z, the following one the new z
      run_uinstr(mk(1'b0, 1'b0, 4'b0001, 3'd2, 11'h060), 1'b0, 4'b0100, 0, "orcc_brz_old");
      run_uinstr(mk(1'b0, 1'b0, 4'b1100, 3'd2, 11'h070), 1'b0, 4'b0000, 0, "brz_new");
   endtask

   task automatic test_decode_ir13();
      run_uinstr(mk(1'b0, 1'b0, 4'b0100, 3'd7, 11'h3C3), 1'b0, 4'd0, 0, "decode");
      run_uinstr(mk(1'b0, 1'b0, 4'b0100, 3'd5, 11'h0AA), 1'b1, 4'd0, 0, "ir13_one");
      run_uinstr(mk(1'b0, 1'b0, 4'b0100, 3'd5, 11'h0AB), 1'b0, 4'd0, 0, "ir13_zero");
   endtask

   task automatic test_mem_wait();
      run_uinstr(mk(1'b1, 1'b0, 4'b0100, 3'd6, 11'h444), 1'b0, 4'd0, 3, "read_wait3");
      run_uinstr(mk(1'b1, 1'b1, 4'b0100, 3'd0, 11'h445), 1'b0, 4'd0, 1, "rdwr_as_read");
      run_uinstr(mk(1'b0, 1'b1, 4'b0010, 3'd2, 11'h446), 1'b0, 4'b0101, 2, "write_wait2");
      run_uinstr(mk(1'b0, 1'b1, 4'b0100, 3'd2, 11'h447), 1'b0, 4'd0, 0, "write_ready");
   endtask

   task automatic test_memwait_reset();
      run_uinstr(mk(1'b0, 1'b0, 4'b0000, 3'd0, 11'h001), 1'b0, 4'b0000, 0, "mwr_clear");
      uword = mk(1'b1, 1'b0, 4'b0001, 3'd6, 11'h222); cs_addr = 11'h0F0;
      alu_flags = 4'b1111; mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (mrd !== 1'b1 || strobe !== 1'b0) begin
         errors++;
         $display("FAIL memwait_before_reset: rd=%b strobe=%b want 1 0", mrd, strobe);
      end
      checks++;
      rst_n = 1'b0;
      #1;
      if (mrd !== 1'b0 || mwr !== 1'b0 || psr !== 4'd0) begin
         errors++;
         $display("FAIL memwait_reset: rd=%b wr=%b psr=%b want 0 0 0000", mrd, mwr, psr);
      end
      checks++;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      if (psr !== 4'd0 || mir !== 41'd0) begin
         errors++;
         $display("FAIL memwait_reset_hold: psr=%b mir=%h want 0000 0", psr, mir);
      end
      checks++;
      m_psr = 4'd0;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic        rd;
      logic        wr;
      int          nr;
      for (int k = 0; k < 60; k++) begin
         rd = 1'($urandom_range(0, 3) == 0);
         wr = 1'($urandom_range(0, 3) == 0);
         nr = (rd | wr) ? int'($urandom_range(0, 3)) : 0;
         run_uinstr(mk(rd, wr, 4'($urandom), 3'($urandom), 11'($urandom)),
                    1'($urandom), 4'($urandom), nr, "random");
      end
   endtask

   initial begin
      test_reset();
      test_jump_always();
      test_psr_cc();
      test_decode_ir13();
      test_mem_wait();
      test_memwait_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
